// File: rtl/alu_op_issuer.sv
// alu_op_issuer: command FIFO -> registered ALU issue -> latency-tracking pipe -> FWFT result FIFO.
// Optional capture-time check of alu_c against the issued operands: define ALU_OP_ISSUER_SELF_CHECK_EN.
module alu_op_issuer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [1:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_op,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              chk_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Stage 0 mirrors the alu_* registers; stages 1..ALU_LAT follow the ALU's own latency.
  localparam int PIPE_D = ALU_LAT + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + PIPE_D + 1);
  localparam logic [AW:0]      DEPTH_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CRED = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // ---------------- command FIFO ----------------
  logic [1:0]        cmd_op_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] cmd_a_mem  [FIFO_DEPTH];
  logic [DATA_W-1:0] cmd_b_mem  [FIFO_DEPTH];
  logic [AW-1:0]     cmd_wr_reg, cmd_rd_reg;
  logic [AW:0]       cmd_count_reg;

  logic cmd_empty, cmd_full, accept, issue, credit_ok, pipe_empty, capture, rsp_pop;
  logic [1:0]        issue_op;
  logic [DATA_W-1:0] issue_a, issue_b;
  logic [CNT_W-1:0]  inflight;

  assign cmd_empty = (cmd_count_reg == '0);
  assign cmd_full  = (cmd_count_reg == DEPTH_CNT);
  assign cmd_ready = !cmd_full && (state_reg != FLUSH);
  // A flush in the same cycle drops the offered command even if cmd_ready was high.
  assign accept    = cmd_valid && cmd_ready && !flush;

  assign issue_op = cmd_op_mem[cmd_rd_reg];
  assign issue_a  = cmd_a_mem[cmd_rd_reg];
  assign issue_b  = cmd_b_mem[cmd_rd_reg];

  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_op_mem[cmd_wr_reg] <= cmd_op;
      cmd_a_mem[cmd_wr_reg]  <= cmd_a;
      cmd_b_mem[cmd_wr_reg]  <= cmd_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_wr_reg    <= '0;
      cmd_rd_reg    <= '0;
      cmd_count_reg <= '0;
    end else if (flush) begin
      cmd_wr_reg    <= '0;
      cmd_rd_reg    <= '0;
      cmd_count_reg <= '0;
    end else begin
      if (accept) cmd_wr_reg <= cmd_wr_reg + AW'(1);
      if (issue)  cmd_rd_reg <= cmd_rd_reg + AW'(1);
      case ({accept, issue})
        2'b10:   cmd_count_reg <= cmd_count_reg + (AW+1)'(1);
        2'b01:   cmd_count_reg <= cmd_count_reg - (AW+1)'(1);
        default: cmd_count_reg <= cmd_count_reg;
      endcase
    end
  end

  // ---------------- issue ----------------
  logic [AW:0] rsp_count_reg;

  // Every issued op owns a result slot from issue until it is read out.
  assign credit_ok = ((CNT_W'(rsp_count_reg) + inflight) < DEPTH_CRED);
  assign issue     = (state_reg == RUN) && !flush && !cmd_empty && credit_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (issue) begin
      alu_opcode <= issue_op;
      alu_a      <= issue_a;
      alu_b      <= issue_b;
    end
  end

  // ---------------- latency pipe ----------------
  logic       pipe_valid_reg [PIPE_D];
  logic [1:0] pipe_op_reg    [PIPE_D];

  generate
    for (genvar gi = 0; gi < PIPE_D; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            pipe_valid_reg[gi] <= 1'b0;
            pipe_op_reg[gi]    <= '0;
          end else begin
            pipe_valid_reg[gi] <= issue;
            if (issue) pipe_op_reg[gi] <= issue_op;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            pipe_valid_reg[gi] <= 1'b0;
            pipe_op_reg[gi]    <= '0;
          end else begin
            pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
            pipe_op_reg[gi]    <= pipe_op_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_D; i++) begin
      inflight = inflight + CNT_W'(pipe_valid_reg[i]);
    end
  end

  assign pipe_empty = (inflight == '0);
  assign capture    = pipe_valid_reg[PIPE_D-1];

  // ---------------- result FIFO (first-word fall-through) ----------------
  logic [1:0]        rsp_op_mem   [FIFO_DEPTH];
  logic [DATA_W-1:0] rsp_data_mem [FIFO_DEPTH];
  logic [AW-1:0]     rsp_wr_reg, rsp_rd_reg;

  assign rsp_valid = (rsp_count_reg != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_op    = rsp_valid ? rsp_op_mem[rsp_rd_reg]   : '0;
  assign rsp_data  = rsp_valid ? rsp_data_mem[rsp_rd_reg] : '0;

  always_ff @(posedge clk) begin
    if (capture) begin
      rsp_op_mem[rsp_wr_reg]   <= pipe_op_reg[PIPE_D-1];
      rsp_data_mem[rsp_wr_reg] <= alu_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_wr_reg    <= '0;
      rsp_rd_reg    <= '0;
      rsp_count_reg <= '0;
    end else begin
      if (capture) rsp_wr_reg <= rsp_wr_reg + AW'(1);
      if (rsp_pop) rsp_rd_reg <= rsp_rd_reg + AW'(1);
      case ({capture, rsp_pop})
        2'b10:   rsp_count_reg <= rsp_count_reg + (AW+1)'(1);
        2'b01:   rsp_count_reg <= rsp_count_reg - (AW+1)'(1);
        default: rsp_count_reg <= rsp_count_reg;
      endcase
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!cmd_empty || accept) state_next = RUN;
      RUN:     if (cmd_empty && pipe_empty && !accept) state_next = IDLE;
      FLUSH:   if (pipe_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = FLUSH;
  end

  assign busy = (state_reg != IDLE);

  // ---------------- optional result self-check ----------------
`ifdef ALU_OP_ISSUER_SELF_CHECK_EN
  logic [DATA_W-1:0] pipe_a_reg [PIPE_D];
  logic [DATA_W-1:0] pipe_b_reg [PIPE_D];
  logic [DATA_W-1:0] chk_exp;
  logic              chk_bad, chk_err_reg;

  generate
    for (genvar gi = 0; gi < PIPE_D; gi++) begin : g_chk_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            pipe_a_reg[gi] <= '0;
            pipe_b_reg[gi] <= '0;
          end else if (issue) begin
            pipe_a_reg[gi] <= issue_a;
            pipe_b_reg[gi] <= issue_b;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            pipe_a_reg[gi] <= '0;
            pipe_b_reg[gi] <= '0;
          end else begin
            pipe_a_reg[gi] <= pipe_a_reg[gi-1];
            pipe_b_reg[gi] <= pipe_b_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    chk_exp = '0;
    case (pipe_op_reg[PIPE_D-1])
      2'd0:    chk_exp = pipe_a_reg[PIPE_D-1] + pipe_b_reg[PIPE_D-1];
      2'd1:    chk_exp = pipe_a_reg[PIPE_D-1] - pipe_b_reg[PIPE_D-1];
      2'd2:    chk_exp = ~pipe_a_reg[PIPE_D-1];
      default: chk_exp = {{(DATA_W-1){1'b0}}, |pipe_b_reg[PIPE_D-1]};
    endcase
  end

  assign chk_bad = capture && (alu_c != chk_exp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chk_err_reg <= 1'b0;
    else if (chk_bad) chk_err_reg <= 1'b1;
  end

  assign chk_err = chk_err_reg;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && chk_bad)
      $error("alu_op_issuer: ALU result wrong op=%0d a=%0h b=%0h c=%0h", pipe_op_reg[PIPE_D-1],
             pipe_a_reg[PIPE_D-1], pipe_b_reg[PIPE_D-1], alu_c);
  end
`endif
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: behavioural registered ALU, table-driven vectors, scoreboard of expected results,
// and hand-written sequences for latency, back-pressure, flush and mid-operation reset.
module tb_alu_op_issuer;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int ALU_LAT    = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a, cmd_b;
  logic [1:0]        alu_opcode;
  logic [DATA_W-1:0] alu_a, alu_b, alu_c;
  logic              flush;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_op;
  logic [DATA_W-1:0] rsp_data;
  logic              busy, chk_err;

  always #5 clk = ~clk;

  alu_op_issuer #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
    .busy(busy), .chk_err(chk_err)
  );

  typedef struct {
    logic [1:0]        op;
    logic [DATA_W-1:0] data;
  } rsp_t;

  typedef struct {
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] res;
  } vec_t;

  rsp_t exp_q [$];
  rsp_t mon_e;
  int   checks = 0;
  int   passed = 0;
  int   n_rsp  = 0;
  bit   fault_en = 1'b0;

  // Behavioural ALU with a registered C, ALU_LAT cycles behind its inputs.
  function automatic logic [DATA_W-1:0] alu_f(input logic [1:0] op, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return ~a;
      default: return {{(DATA_W-1){1'b0}}, |b};
    endcase
  endfunction

  logic [DATA_W-1:0] c_pipe [ALU_LAT];
  always @(posedge clk) begin
    if (fault_en && alu_opcode == 2'd0 && alu_a == DATA_W'(1) && alu_b == DATA_W'(1)) c_pipe[0] <= '0;
    else c_pipe[0] <= alu_f(alu_opcode, alu_a, alu_b);
    for (int i = 1; i < ALU_LAT; i++) c_pipe[i] <= c_pipe[i-1];
  end
  assign alu_c = c_pipe[ALU_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: inputs change 1 time unit after posedge, so negedge sees a settled cycle.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      n_rsp++;
      $display("rsp %0d: op=%0d data=%02h", n_rsp, rsp_op, rsp_data);
      check("rsp_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("rsp_op", 32'(rsp_op), 32'(mon_e.op));
        check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [DATA_W-1:0] res, input bit track);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("cmd_accept_timeout", 32'(cmd_ready), 32'(1));
    else if (track) exp_q.push_back('{op, res});
    $display("cmd op=%0d a=%02h b=%02h%s", op, a, b, track ? "" : " (discard expected)");
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_all_results", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic wait_not_busy(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("busy_clears", 32'(busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    int   n_acc;

    vecs[0] = '{2'd0, 8'd5,  8'd3,  8'd8};
    vecs[1] = '{2'd1, 8'd2,  8'd5,  8'hFD};
    vecs[2] = '{2'd2, 8'hF0, 8'h00, 8'h0F};
    vecs[3] = '{2'd3, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{2'd3, 8'h00, 8'h40, 8'h01};
    vecs[5] = '{2'd0, 8'hFF, 8'h01, 8'h00};
    vecs[6] = '{2'd1, 8'h00, 8'h01, 8'hFF};
    vecs[7] = '{2'd2, 8'h00, 8'h55, 8'hFF};
    vecs[8] = '{2'd3, 8'hAA, 8'h80, 8'h01};
    vecs[9] = '{2'd0, 8'h80, 8'h80, 8'h00};

    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    flush = 1'b0; rsp_ready = 1'b0;

    // Reset state.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_alu_opcode", 32'(alu_opcode), 32'(0));
    check("rst_alu_a", 32'(alu_a), 32'(0));
    check("rst_alu_b", 32'(alu_b), 32'(0));
    check("rst_rsp_op", 32'(rsp_op), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_chk_err", 32'(chk_err), 32'(0));
    reset = 1'b1;
    tick();
    tick();

    // First-result latency: rsp_valid appears ALU_LAT+2 edges after the accepting edge.
    send(2'd0, 8'd5, 8'd3, 8'd8, 1'b1);
    for (int k = 0; k <= ALU_LAT + 2; k++) begin
      @(negedge clk);
      check("latency_rsp_valid", 32'(rsp_valid), 32'(k == ALU_LAT + 2));
    end
    check("first_rsp_op", 32'(rsp_op), 32'(0));
    check("first_rsp_data", 32'(rsp_data), 32'(8));
    tick();
    drain(20);

    // Back-to-back table vectors.
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, 1'b1);
    drain(50);
    wait_not_busy(10);
    check("vec_rsp_empty", 32'(rsp_valid), 32'(0));

    // Back-pressure: both FIFOs fill, cmd_ready drops after 2*FIFO_DEPTH accepts.
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      cmd_op    = 2'd0;
      cmd_a     = DATA_W'(n_acc);
      cmd_b     = 8'd1;
      cmd_valid = (n_acc < 2 * FIFO_DEPTH + 1);
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back('{2'd0, DATA_W'(n_acc + 1)});
        $display("cmd op=0 a=%02h b=01", n_acc);
        n_acc++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    check("fill_accepts", 32'(n_acc), 32'(2 * FIFO_DEPTH));
    check("fill_cmd_ready", 32'(cmd_ready), 32'(0));
    check("fill_rsp_valid", 32'(rsp_valid), 32'(1));
    rsp_ready = 1'b1;
    send(2'd0, DATA_W'(2 * FIFO_DEPTH), 8'd1, DATA_W'(2 * FIFO_DEPTH + 1), 1'b1);
    drain(60);
    wait_not_busy(10);

    // Flush with one op in flight and two queued behind it.
    rsp_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) send(2'd0, DATA_W'(8'h10 + i), 8'h00, DATA_W'(8'h10 + i), 1'b1);
    repeat (6) tick();
    send(2'd1, 8'h20, 8'h01, 8'h1F, 1'b1);
    send(2'd2, 8'h30, 8'h00, 8'h00, 1'b0);
    send(2'd3, 8'h31, 8'h01, 8'h00, 1'b0);
    check("no_credit_alu_a_hold", 32'(alu_a), 32'(8'h13));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'(1));
    check("flush_cmd_ready", 32'(cmd_ready), 32'(0));
    wait_not_busy(20);
    check("flush_cmd_ready_after", 32'(cmd_ready), 32'(1));
    check("flush_alu_a_last_issue", 32'(alu_a), 32'(8'h20));
    drain(30);
    repeat (5) tick();
    check("flush_no_extra_rsp", 32'(rsp_valid), 32'(0));

    // Reset with two results unread and two in flight.
    rsp_ready = 1'b0;
    send(2'd0, 8'd1, 8'd2, 8'd3, 1'b0);
    send(2'd0, 8'd3, 8'd4, 8'd7, 1'b0);
    repeat (5) tick();
    send(2'd1, 8'd9, 8'd1, 8'd8, 1'b0);
    send(2'd1, 8'd7, 8'd1, 8'd6, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("midrst_alu_a", 32'(alu_a), 32'(0));
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rsp_ready = 1'b1;
    repeat (8) tick();
    check("midrst_no_stale", 32'(rsp_valid), 32'(0));
    send(2'd0, 8'd7, 8'd9, 8'd16, 1'b1);
    drain(20);

    // Faulty ALU result on Add 1+1.
    fault_en = 1'b1;
    send(2'd0, 8'd1, 8'd1, 8'd0, 1'b1);
    drain(20);
`ifdef ALU_OP_ISSUER_SELF_CHECK_EN
    check("chk_err_set", 32'(chk_err), 32'(1));
    send(2'd0, 8'd2, 8'd3, 8'd5, 1'b1);
    drain(20);
    check("chk_err_sticky", 32'(chk_err), 32'(1));
    fault_en = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("chk_err_cleared", 32'(chk_err), 32'(0));
`else
    check("chk_err_tied_low", 32'(chk_err), 32'(0));
`endif
    fault_en = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
